// File: rtl/channel_emu_pkg.sv
// Shared fixed-point helpers for the SerDes channel emulator: saturation,
// NRZ mapping, LFSR stepping and accumulator sizing.
package channel_emu_pkg;

    // Working width for intermediate sums; comfortably wider than any path.
    localparam int WIDE_W = 48;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_max(input int w);
        logic signed [WIDE_W-1:0] one;
        one = WIDE_W'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic is_sat(input logic signed [WIDE_W-1:0] v, input int w);
        return (v > sat_max(w)) || (v < (-sat_max(w) - WIDE_W'(1)));
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat(input logic signed [WIDE_W-1:0] v, input int w);
        logic signed [WIDE_W-1:0] lo;
        lo = -sat_max(w) - WIDE_W'(1);
        if (v > sat_max(w))
            return sat_max(w);
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic signed [WIDE_W-1:0] nrz(input logic b, input int amp);
        logic signed [WIDE_W-1:0] a;
        a = WIDE_W'(amp);
        return b ? a : -a;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/channel_fir_stage.sv
// Stage 1 of the channel emulator: NRZ delay line, coefficient register file
// and the registered, saturated FIR output.
module channel_fir_stage
    import channel_emu_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 10,
    parameter int FRAC   = 8,
    parameter int NTAPS  = 4,
    parameter int AMP    = 1024,
    parameter int ADDR_W = $clog2(NTAPS) | 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_in,
    input  logic                     in_valid,
    input  logic                     coef_wr_en,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic signed [DATA_W-1:0] x,
    output logic                     v1,
    output logic                     x_clamp
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
    localparam int HIST  = (NTAPS > 1) ? NTAPS - 1 : 1;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);

    logic signed [DATA_W-1:0] hist_q [HIST];
    logic signed [COEF_W-1:0] coef_q [NTAPS];
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  acc;
    logic signed [WIDE_W-1:0] acc_shr;

    // The incoming bit is tap 0 so the sample is filtered in its own accept cycle.
    always_comb begin
        sample = DATA_W'(nrz(data_in, AMP));
        acc    = ACC_W'(sample) * ACC_W'(coef_q[0]);
        for (int k = 1; k < NTAPS; k++)
            acc = acc + ACC_W'(hist_q[k-1]) * ACC_W'(coef_q[k]);
        acc_shr = WIDE_W'(acc >>> FRAC);
    end

    assign x_clamp = in_valid & is_sat(acc_shr, DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            v1 <= 1'b0;
            for (int k = 0; k < HIST; k++)
                hist_q[k] <= '0;
            for (int k = 0; k < NTAPS; k++)
                coef_q[k] <= (k == 0) ? COEF_ONE : '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                x         <= DATA_W'(sat(acc_shr, DATA_W));
                hist_q[0] <= sample;
                for (int k = 1; k < HIST; k++)
                    hist_q[k] <= hist_q[k-1];
            end
            for (int k = 0; k < NTAPS; k++)
                if (coef_wr_en && int'(coef_addr) == k)
                    coef_q[k] <= coef_wdata;
        end
    end

endmodule

// File: rtl/channel_fir_iir_emu.sv
// Lossy SerDes lane emulator: NRZ + FIR ISI, optional LFSR noise and a
// one-pole IIR low-pass, one sample per cycle with two cycles of latency.
module channel_fir_iir_emu
    import channel_emu_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int COEF_W   = 10,
    parameter int FRAC     = 8,
    parameter int NTAPS    = 4,
    parameter int AMP      = 1024,
    parameter int BETA_DEF = 64,
    parameter int NOISE_W  = 4
) (
    input  logic                             Sample_CLK,
    input  logic                             Rst_n,
    input  logic                             Data_in,
    input  logic                             In_valid,
    input  logic                             Bypass,
    input  logic                             Coef_wr_en,
    input  logic [($clog2(NTAPS) | 1) - 1:0] Coef_addr,
    input  logic [COEF_W-1:0]                Coef_wdata,
    input  logic                             Beta_wr_en,
    input  logic [FRAC:0]                    Beta_wdata,
    input  logic                             Noise_en,
    input  logic                             Sat_clr,
    output logic [DATA_W-1:0]                Ynew,
    output logic                             Out_valid,
    output logic                             Sat_flag
);

    localparam int DW1 = DATA_W + 1;
    localparam int PW  = DATA_W + FRAC + 3;
    localparam logic [FRAC:0] BETA_MAX = (FRAC + 1)'(1 << FRAC);
    localparam logic [FRAC:0] BETA_RST = (FRAC + 1)'(BETA_DEF);

    logic signed [DATA_W-1:0] x, xn, y_q, y_next;
    logic                     v1, fir_clamp, xn_clamp, y_clamp, sat_set;
    logic [15:0]              lfsr_q;
    logic [FRAC:0]            beta_q;
    logic signed [WIDE_W-1:0] noise, xn_wide, y_wide;
    logic signed [DW1-1:0]    diff;
    logic signed [PW-1:0]     prod;

    channel_fir_stage #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .NTAPS  (NTAPS),
        .AMP    (AMP)
    ) u_fir (
        .clk        (Sample_CLK),
        .rst_n      (Rst_n),
        .data_in    (Data_in),
        .in_valid   (In_valid),
        .coef_wr_en (Coef_wr_en),
        .coef_addr  (Coef_addr),
        .coef_wdata ($signed(Coef_wdata)),
        .x          (x),
        .v1         (v1),
        .x_clamp    (fir_clamp)
    );

    // alpha = 1 - Beta is folded into y + Beta*(xn - y).
    always_comb begin
        noise    = Noise_en ? WIDE_W'($signed(lfsr_q[NOISE_W-1:0])) : '0;
        xn_wide  = WIDE_W'(x) + noise;
        xn_clamp = is_sat(xn_wide, DATA_W);
        xn       = DATA_W'(sat(xn_wide, DATA_W));
        diff     = DW1'(xn) - DW1'(y_q);
        prod     = PW'(diff) * PW'($signed({1'b0, beta_q}));
        y_wide   = WIDE_W'(y_q) + WIDE_W'(prod >>> FRAC);
        y_clamp  = ~Bypass & is_sat(y_wide, DATA_W);
        y_next   = Bypass ? xn : DATA_W'(sat(y_wide, DATA_W));
    end

    assign sat_set = fir_clamp | (v1 & (xn_clamp | y_clamp));
    assign Ynew    = y_q;

    always_ff @(posedge Sample_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr_q    <= LFSR_SEED;
            beta_q    <= BETA_RST;
            y_q       <= '0;
            Out_valid <= 1'b0;
            Sat_flag  <= 1'b0;
        end else begin
            if (In_valid)
                lfsr_q <= lfsr_step(lfsr_q);
            if (Beta_wr_en)
                beta_q <= (Beta_wdata > BETA_MAX) ? BETA_MAX : Beta_wdata;
            if (v1)
                y_q <= y_next;
            Out_valid <= v1;
            // A clamp in the same cycle as a clear keeps the flag set.
            if (sat_set)
                Sat_flag <= 1'b1;
            else if (Sat_clr)
                Sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_fir_iir_emu.sv
// Bench for channel_fir_iir_emu: directed channel scenarios plus randomized
// bursts scored against an arithmetic model of the lane.
module tb_channel_fir_iir_emu;

    localparam int DATA_W = 12;
    localparam int COEF_W = 10;
    localparam int FRAC   = 8;
    localparam int NTAPS  = 4;
    localparam int AMP    = 1024;
    localparam int ADDR_W = 3;
    localparam int YMAX   = (1 << (DATA_W - 1)) - 1;
    localparam int YMIN   = -(1 << (DATA_W - 1));

    logic              sample_clk = 1'b0;
    logic              rst_n;
    logic              data_in, in_valid, bypass, coef_wr_en;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              beta_wr_en;
    logic [FRAC:0]     beta_wdata;
    logic              noise_en, sat_clr;
    logic [DATA_W-1:0] ynew;
    logic              out_valid, sat_flag;

    channel_fir_iir_emu #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .FRAC     (FRAC),
        .NTAPS    (NTAPS),
        .AMP      (AMP),
        .BETA_DEF (64),
        .NOISE_W  (4)
    ) dut (
        .Sample_CLK (sample_clk),
        .Rst_n      (rst_n),
        .Data_in    (data_in),
        .In_valid   (in_valid),
        .Bypass     (bypass),
        .Coef_wr_en (coef_wr_en),
        .Coef_addr  (coef_addr),
        .Coef_wdata (coef_wdata),
        .Beta_wr_en (beta_wr_en),
        .Beta_wdata (beta_wdata),
        .Noise_en   (noise_en),
        .Sat_clr    (sat_clr),
        .Ynew       (ynew),
        .Out_valid  (out_valid),
        .Sat_flag   (sat_flag)
    );

    // Clock / cycle count
    always #5 sample_clk = ~sample_clk;

    int cyc = 0;
    always @(posedge sample_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_t_q[$];

    // Reference model state: m_hist[0] is the newest line sample.
    int m_hist [NTAPS];
    int m_coef [NTAPS];
    int m_beta;
    int m_y;
    int m_lfsr;
    bit m_sat;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0)))
            q = q - 1;
        return q;
    endfunction

    function automatic int sat_m(input longint v);
        if (v > YMAX) begin
            m_sat = 1'b1;
            return YMAX;
        end
        if (v < YMIN) begin
            m_sat = 1'b1;
            return YMIN;
        end
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            m_hist[k] = 0;
            m_coef[k] = (k == 0) ? (1 << FRAC) : 0;
        end
        m_beta = 64;
        m_y    = 0;
        m_lfsr = 'hACE1;
        m_sat  = 1'b0;
    endtask

    task automatic model_sample(input bit b, input bit use_c, input int cval);
        longint acc;
        int     x, n, xn, fb, yexp;
        for (int k = NTAPS - 1; k > 0; k--)
            m_hist[k] = m_hist[k-1];
        m_hist[0] = b ? AMP : -AMP;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
            acc += longint'(m_hist[k]) * m_coef[k];
        x = sat_m(fdiv(acc, 1 << FRAC));
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
        n = 0;
        if (noise_en) begin
            n = m_lfsr & 15;
            if (n >= 8) n -= 16;
        end
        xn = sat_m(longint'(x) + n);
        if (bypass)
            m_y = xn;
        else
            m_y = sat_m(longint'(m_y) + fdiv(longint'(xn - m_y) * m_beta, 1 << FRAC));
        yexp = use_c ? cval : m_y;
        exp_q.push_back(DATA_W'(yexp));
        exp_t_q.push_back(cyc + 2);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic send(input bit b, input bit use_c = 1'b0, input int cval = 0);
        data_in  = b;
        in_valid = 1'b1;
        model_sample(b, use_c, cval);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_wr_en = 1'b1;
        coef_addr  = ADDR_W'(addr);
        coef_wdata = COEF_W'(val);
        if (addr < NTAPS) m_coef[addr] = val;
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic write_beta(input int val);
        beta_wr_en = 1'b1;
        beta_wdata = (FRAC + 1)'(val);
        m_beta     = (val > (1 << FRAC)) ? (1 << FRAC) : val;
        tick();
        beta_wr_en = 1'b0;
    endtask

    task automatic clear_sat();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        m_sat   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            tick();
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            exp_t_q.delete();
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ynew", int'($signed(ynew)), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        exp_q.delete();
        exp_t_q.delete();
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge sample_clk) begin
        logic [DATA_W-1:0] e;
        int                t;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("ynew", int'($signed(ynew)), int'($signed(e)));
                check("latency", cyc, t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        data_in    = 1'b0;
        in_valid   = 1'b0;
        bypass     = 1'b0;
        coef_wr_en = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        beta_wr_en = 1'b0;
        beta_wdata = '0;
        noise_en   = 1'b0;
        sat_clr    = 1'b0;
        model_reset();
        repeat (2) tick();
        check("init_ynew", int'($signed(ynew)), 0);
        check("init_out_valid", int'(out_valid), 0);
        check("init_sat_flag", int'(sat_flag), 0);
        rst_n = 1'b1;
        tick();

        // NRZ pass-through with default coefficients
        bypass = 1'b1;
        send(1'b1, 1'b1, 1024);
        send(1'b1, 1'b1, 1024);
        send(1'b0, 1'b1, -1024);
        send(1'b0, 1'b1, -1024);
        drain();

        // Post-cursor ISI
        do_reset();
        bypass = 1'b1;
        write_coef(1, 128);
        send(1'b1, 1'b1, 1024);
        send(1'b0, 1'b1, -512);
        send(1'b1, 1'b1, 512);
        send(1'b0, 1'b1, -512);
        drain();

        // IIR step response
        do_reset();
        bypass = 1'b0;
        send(1'b1, 1'b1, 256);
        send(1'b1, 1'b1, 448);
        send(1'b1, 1'b1, 592);
        send(1'b1, 1'b1, 700);
        repeat (20) send(1'b1);
        drain();

        // Saturation and sticky flag
        do_reset();
        bypass = 1'b1;
        for (int k = 1; k < NTAPS; k++) write_coef(k, 256);
        send(1'b1, 1'b1, 1024);
        repeat (3) send(1'b1, 1'b1, 2047);
        drain();
        check("sat_after_clamp", int'(sat_flag), 1);
        repeat (5) tick();
        check("sat_hold_idle", int'(sat_flag), 1);
        clear_sat();
        check("sat_clr_idle", int'(sat_flag), 0);
        sat_clr = 1'b1;
        send(1'b1, 1'b1, 2047);
        sat_clr = 1'b0;
        check("sat_clr_vs_clamp", int'(sat_flag), 1);
        drain();
        clear_sat();

        // Coefficient write in the accept cycle, and an out-of-range address
        do_reset();
        bypass = 1'b1;
        send(1'b1, 1'b1, 1024);
        data_in    = 1'b1;
        in_valid   = 1'b1;
        coef_wr_en = 1'b1;
        coef_addr  = '0;
        coef_wdata = COEF_W'(128);
        model_sample(1'b1, 1'b1, 1024);
        m_coef[0]  = 128;
        tick();
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        send(1'b1, 1'b1, 512);
        write_coef(4, 0);
        send(1'b1, 1'b1, 512);
        drain();

        // Reset mid-stream discards in-flight samples and restores coefficients
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 400)) - 100);
        bypass   = 1'b0;
        noise_en = 1'b1;
        repeat (6) send(1'($urandom_range(0, 1)));
        do_reset();
        noise_en = 1'b0;
        bypass   = 1'b1;
        send(1'b1, 1'b1, 1024);
        send(1'b0, 1'b1, -1024);
        drain();

        // Randomized bursts against the model
        do_reset();
        for (int b = 0; b < 25; b++) begin
            int len;
            bypass   = 1'($urandom_range(0, 1));
            noise_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                write_coef(int'($urandom_range(0, NTAPS)), int'($urandom_range(0, 1023)) - 512);
            if ($urandom_range(0, 2) == 0)
                write_beta(int'($urandom_range(0, 400)));
            len = int'($urandom_range(4, 16));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(1'($urandom_range(0, 1)));
            end
            drain();
            check("sat_flag_burst", int'(sat_flag), int'(m_sat));
            if (m_sat) clear_sat();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
